// File: rtl/adc_dc_remover_if.sv
// Sample-stream bundle between the ADC sampler, the DC remover and the Costas demodulator.
// Carries one inbound offset-binary stream and one outbound signed, DC-corrected stream.
// Strobe-only, no ready: a consumer must accept a sample on every cycle its strobe is high.
//
// Ports (signals):
//   in_valid/in_data/in_otr    : sampler -> remover, offset-binary sample + over-range flag
//   out_valid/out_data/out_otr : remover -> demodulator, signed sample + aligned over-range flag
// Modports: master = stream source/sink side (bench or neighbours), slave = adc_dc_remover.
interface adc_dc_remover_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_otr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_otr;

    modport master (
        output in_valid,
        output in_data,
        output in_otr,
        input  out_valid,
        input  out_data,
        input  out_otr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_otr,
        output out_valid,
        output out_data,
        output out_otr
    );
endinterface

// File: rtl/adc_dc_remover.sv
// Converts offset-binary ADC samples to signed, removes a block-averaged DC offset with saturation.
// Latency: exactly 2 sys_clk cycles from in_valid to out_valid; one sample per cycle sustained.
// No backpressure: strobed stream, every in_valid produces exactly one out_valid two cycles later.
//
// Ports:
//   sys_clk, rst : clock and synchronous active-high reset
//   bus          : stream interface (in_valid/in_data/in_otr in, out_valid/out_data/out_otr out)
//   dc_freeze    : holds dc_est and stalls the block accumulator while high
//   dc_est       : signed current DC estimate (0 until the first block completes)
//   dc_locked    : high once the first full block has been averaged
//   otr_cnt      : saturating count of valid samples flagged over-range
module adc_dc_remover #(
    parameter int AVG_LOG2  = 8,
    parameter int OTR_CNT_W = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    adc_dc_remover_if.slave      bus,
    input  logic                 dc_freeze,
    output logic [7:0]           dc_est,
    output logic                 dc_locked,
    output logic [OTR_CNT_W-1:0] otr_cnt
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic {
        ACQ,
        TRACK
    } state_t;

    // Stage 1: sign-converted sample and its qualifiers
    logic signed [7:0]      s1_q;
    logic                   v1_q;
    logic                   otr1_q;

    // Stage 2: corrected output
    logic [7:0]             out_data_q;
    logic                   out_valid_q;
    logic                   out_otr_q;

    // DC estimation
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
    logic [7:0]              dc_est_q, dc_est_d;
    state_t                  state_q, state_d;

    logic [OTR_CNT_W-1:0]    otr_cnt_q;

    logic signed [ACC_W-1:0] s1_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_en;
    logic signed [8:0]       diff;
    logic [7:0]              diff_sat;

    // The accumulator is wide enough for N full-scale samples, so acc + s1 never wraps.
    assign s1_ext  = {{AVG_LOG2{s1_q[7]}}, s1_q};
    assign acc_sum = acc_q + s1_ext;
    assign acc_en  = v1_q && !dc_freeze;

    // 9-bit difference covers the full [-255, +255] range before clamping.
    assign diff = $signed({s1_q[7], s1_q}) - $signed({dc_estq_sign(dc_est_q), dc_est_q});

    function automatic logic dc_estq_sign(input logic [7:0] v);
        return v[7];
    endfunction

    // Overflow of the 8-bit result shows up as a mismatch between the top two bits.
    always_comb begin
        diff_sat = diff[7:0];
        if (diff[8:7] == 2'b01) begin
            diff_sat = 8'h7F;
        end else if (diff[8:7] == 2'b10) begin
            diff_sat = 8'h80;
        end
    end

    // Block accumulator / estimator next-state.
    // Taking bits [AVG_LOG2 +: 8] of the signed sum is the arithmetic shift right by AVG_LOG2,
    // i.e. the average rounded toward minus infinity.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dc_est_d = dc_est_q;
        state_d  = state_q;
        if (acc_en) begin
            if (cnt_q == CNT_LAST) begin
                dc_est_d = acc_sum[AVG_LOG2 +: 8];
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = TRACK;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            otr1_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_otr_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            dc_est_q    <= '0;
            state_q     <= ACQ;
            otr_cnt_q   <= '0;
        end else begin
            s1_q        <= bus.in_data ^ 8'h80;
            v1_q        <= bus.in_valid;
            otr1_q      <= bus.in_valid & bus.in_otr;
            // Stage 2 uses the estimate from before this edge; a block-end update lands
            // for the following sample.
            out_data_q  <= diff_sat;
            out_valid_q <= v1_q;
            out_otr_q   <= otr1_q;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dc_est_q    <= dc_est_d;
            state_q     <= state_d;
            if (bus.in_valid && bus.in_otr && (otr_cnt_q != '1)) begin
                otr_cnt_q <= otr_cnt_q + OTR_CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_otr   = out_otr_q;
    assign dc_est        = dc_est_q;
    assign dc_locked     = (state_q == TRACK);
    assign otr_cnt       = otr_cnt_q;

endmodule

// File: tb/tb_adc_dc_remover.sv
// Directed bench for adc_dc_remover with AVG_LOG2=4 (16-sample blocks) and a 4-bit OTR counter.
// Inputs are driven #1 after each rising edge and outputs are sampled at the same point.
// Expected values are hand-computed constants plus a small queue for the strobe-pattern step.
module tb_adc_dc_remover;

    logic       sys_clk;
    logic       rst;
    logic       dc_freeze;
    logic [7:0] dc_est;
    logic       dc_locked;
    logic [3:0] otr_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    adc_dc_remover_if bus ();

    adc_dc_remover #(
        .AVG_LOG2  (4),
        .OTR_CNT_W (4)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .bus       (bus),
        .dc_freeze (dc_freeze),
        .dc_est    (dc_est),
        .dc_locked (dc_locked),
        .otr_cnt   (otr_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; returns #1 after the edge that captured it.
    task automatic drive(input logic v, input logic [7:0] d, input logic o);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_otr   = o;
        @(posedge sys_clk);
        #1;
    endtask

    // Reset with valid/otr asserted to show reset dominates the inputs.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_otr   = 1'b1;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_otr   = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp_d;
    logic       v;
    logic       prev_v;
    int         n_sent;
    int         n_recv;

    initial begin
        dc_freeze = 1'b0;

        // ---------------- Reset and basic 0x90 block ----------------
        do_reset(3);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data",  bus.out_data,  8'h00);
        chk("rst_out_otr",   bus.out_otr,   1'b0);
        chk("rst_dc_est",    dc_est,        8'h00);
        chk("rst_locked",    dc_locked,     1'b0);
        chk("rst_otr_cnt",   otr_cnt,       4'h0);

        for (int i = 0; i <= 17; i++) begin
            drive(i <= 16, 8'h90, 1'b0);
            if (i == 0) begin
                chk("basic_lat_no_early_valid", bus.out_valid, 1'b0);
            end else begin
                chk("basic_out_valid", bus.out_valid, 1'b1);
                chk("basic_out_data", bus.out_data, (i - 1 < 16) ? 8'h10 : 8'h00);
            end
            if (i == 15) begin
                chk("basic_not_locked_yet", dc_locked, 1'b0);
                chk("basic_dc_est_acq", dc_est, 8'h00);
            end
            if (i == 16) begin
                chk("basic_dc_est", dc_est, 8'h10);
                chk("basic_locked", dc_locked, 1'b1);
            end
        end

        // ---------------- Saturation ----------------
        do_reset(1);
        repeat (16) drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        chk("sat_dc_est_neg", dc_est, 8'h80);
        drive(1'b1, 8'hFF, 1'b0);
        chk("sat_pos_clamp", bus.out_data, 8'h7F);
        repeat (15) drive(1'b1, 8'hFF, 1'b0);
        chk("sat_dc_est_pos", dc_est, 8'h7F);
        drive(1'b1, 8'h00, 1'b0);
        chk("sat_zero_after_pos_est", bus.out_data, 8'h00);
        drive(1'b0, 8'h00, 1'b0);
        chk("sat_neg_valid", bus.out_valid, 1'b1);
        chk("sat_neg_clamp", bus.out_data, 8'h80);

        // ---------------- Negative truncation ----------------
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i == 15) ? 8'h7F : 8'h80, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("trunc_last_out", bus.out_data, 8'hFF);
        chk("trunc_dc_est", dc_est, 8'hFF);
        chk("trunc_locked", dc_locked, 1'b1);

        // ---------------- Back-to-back then gapped strobes ----------------
        do_reset(1);
        prev_v = 1'b0;
        n_sent = 0;
        n_recv = 0;
        for (int s = 0; s < 60; s++) begin
            v = (s < 20) || ((s < 50) && ((s - 20) % 5 == 0));
            if (v) begin
                exp_q.push_back((n_sent % 2 == 0) ? 8'h01 : 8'hFF);
                drive(1'b1, (n_sent % 2 == 0) ? 8'h81 : 8'h7F, 1'b0);
                n_sent++;
            end else begin
                drive(1'b0, 8'h00, 1'b0);
            end
            chk("strobe_out_valid", bus.out_valid, prev_v);
            if (bus.out_valid === 1'b1) begin
                n_recv++;
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    chk("strobe_out_data", bus.out_data, exp_d);
                end else begin
                    chk("strobe_extra_output", 32'd1, 32'd0);
                end
            end
            prev_v = v;
        end
        chk("strobe_count", n_recv, n_sent);
        chk("strobe_pending", exp_q.size(), 0);
        chk("strobe_dc_est", dc_est, 8'h00);
        chk("strobe_locked", dc_locked, 1'b1);

        // ---------------- Freeze and OTR ----------------
        do_reset(1);
        repeat (10) drive(1'b1, 8'h90, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        dc_freeze = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 8'hFF, j < 3);
            if (j >= 1) begin
                chk("frz_out_data", bus.out_data, 8'h7F);
                chk("frz_out_otr", bus.out_otr, (j - 1) < 3);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        chk("frz_last_out_data", bus.out_data, 8'h7F);
        chk("frz_last_out_otr", bus.out_otr, 1'b0);
        chk("otr_cnt_three", otr_cnt, 4'd3);
        dc_freeze = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("otr_invalid_no_valid", bus.out_valid, 1'b0);
        chk("otr_invalid_ignored", bus.out_otr, 1'b0);
        chk("frz_held_dc_est", dc_est, 8'h00);
        repeat (6) drive(1'b1, 8'h90, 1'b0);
        chk("frz_not_done_locked", dc_locked, 1'b0);
        chk("frz_not_done_dc_est", dc_est, 8'h00);
        drive(1'b0, 8'h00, 1'b0);
        chk("frz_done_dc_est", dc_est, 8'h10);
        chk("frz_done_locked", dc_locked, 1'b1);
        chk("otr_cnt_still_three", otr_cnt, 4'd3);

        // ---------------- OTR counter saturation ----------------
        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 8'h80, 1'b1);
            if (i == 13) chk("otr_cnt_14", otr_cnt, 4'd14);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("otr_cnt_saturated", otr_cnt, 4'hF);

        // ---------------- Reset mid-block ----------------
        do_reset(1);
        repeat (9) drive(1'b1, 8'hFF, 1'b0);
        do_reset(1);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_dc_est", dc_est, 8'h00);
        chk("midrst_otr_cnt", otr_cnt, 4'h0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h84, 1'b0);
            if (i == 1) chk("midrst_first_out", bus.out_data, 8'h04);
            if (i == 15) chk("midrst_not_locked_early", dc_locked, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("midrst_dc_est_final", dc_est, 8'h04);
        chk("midrst_locked", dc_locked, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
